// File: rtl/spi_slave.sv
// SPI responder: oversampled SCLK/CS/MOSI, all four CPOL/CPHA modes, MSB first, single-entry TX buffer.
// Optional sticky RX overrun flag and its clear input exist only when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_WORD   = '1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
`ifdef SPI_SLAVE_OVERRUN_EN
  output logic              overrun_o,
  input  logic              overrun_clr_i,
`endif
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_s, sclk_s, mosi_s;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              prev_sclk_q, prev_sclk_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic              overrun_q, overrun_d;
`endif

  logic              sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic              sample_edge, shift_edge;
  logic              tx_load, rx_done;
  logic [DATA_W-1:0] rx_word;

  // CS synchronizer resets high so a reset never looks like a CS assertion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    end
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise   = sclk_s & ~prev_sclk_q;
  assign sclk_fall   = ~sclk_s & prev_sclk_q;
  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;
  assign rx_word     = {rx_shift_q[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      bit_cnt_q   <= '0;
      prev_sclk_q <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      bit_cnt_q   <= bit_cnt_d;
      prev_sclk_q <= prev_sclk_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
`ifdef SPI_SLAVE_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    bit_cnt_d   = bit_cnt_q;
    prev_sclk_d = sclk_s;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    tx_load     = 1'b0;
    rx_done     = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    overrun_d   = overrun_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!cs_s) begin
          state_d   = ST_ACTIVE;
          mode_d    = mode_i;
          bit_cnt_d = '0;
          tx_load   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // CS release wins over any edge seen in the same cycle; the partial word is dropped.
        if (cs_s) begin
          state_d = ST_IDLE;
        end else if (sample_edge) begin
          rx_shift_d = rx_word;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            rx_done   = 1'b1;
            tx_load   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (shift_edge && (bit_cnt_q != '0)) begin
          tx_shift_d = tx_shift_q << 1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load sees the registered buffer state; a word accepted this cycle waits for the next load.
    if (tx_load) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_WORD;
      end
    end
    if (tx_valid_i && !buf_full_q) begin
      buf_d      = tx_data_i;
      buf_full_d = 1'b1;
    end

    if (rx_done) begin
      rx_data_d  = rx_word;
      rx_valid_d = 1'b1;
    end else if (rx_ready_i && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    if (rx_done && rx_valid_q && !rx_ready_i) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
`endif
  end

  assign busy_o     = (state_q == ST_ACTIVE);
  assign miso_oe_o  = (state_q == ST_ACTIVE);
  assign miso_o     = (state_q == ST_ACTIVE) & tx_shift_q[DATA_W-1];
  assign tx_ready_o = ~buf_full_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
`ifdef SPI_SLAVE_OVERRUN_EN
  assign overrun_o  = overrun_q;
`endif

endmodule
